// File: rtl/loader_pkg.sv
// Shared types and constants for the serial instruction-memory bootloader.
package loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEN0,
        LEN1,
        DATA,
        CHK,
        FAIL
    } loader_state_t;

    localparam logic [7:0]  SYNC_BYTE = 8'hA5;
    localparam int unsigned CHK_W     = 8;

endpackage

// File: rtl/word_packer.sv
// Assembles four little-endian bytes into a 32-bit word; word_valid_o pulses
// the cycle after the fourth byte is taken.
module word_packer (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        clr_i,
    input  logic        byte_valid_i,
    input  logic [7:0]  byte_i,
    output logic [1:0]  idx_o,
    output logic [31:0] word_o,
    output logic        word_valid_o
);
    logic [1:0] idx_q, idx_d;
    logic       word_valid_q, word_valid_d;

    always_comb begin
        idx_d        = idx_q;
        word_valid_d = 1'b0;
        if (clr_i) begin
            idx_d = '0;
        end else if (byte_valid_i) begin
            idx_d        = idx_q + 2'd1;
            word_valid_d = (idx_q == 2'd3);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            idx_q        <= '0;
            word_valid_q <= 1'b0;
        end else begin
            idx_q        <= idx_d;
            word_valid_q <= word_valid_d;
        end
    end

    // One register per byte lane, loaded when the index points at it.
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        logic [7:0] lane_q;

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                lane_q <= '0;
            end else if (byte_valid_i && !clr_i && (idx_q == 2'(gi))) begin
                lane_q <= byte_i;
            end
        end

        assign word_o[gi*8 +: 8] = lane_q;
    end

    assign idx_o        = idx_q;
    assign word_valid_o = word_valid_q;

endmodule

// File: rtl/imem_loader.sv
// Serial bootloader: frames A5/LEN/payload bytes into instruction-memory writes.
// Define IMEM_LOADER_CHECKSUM_EN to require a trailing 8-bit payload checksum.
module imem_loader
    import loader_pkg::*;
#(
    parameter int unsigned MAX_WORDS      = 8192,
    parameter int unsigned TIMEOUT_CYCLES = 5_000_000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [7:0]  rx_data_i,
    input  logic        rx_valid_i,
    output logic [29:0] imem_a_o,
    output logic        imem_we_o,
    output logic [31:0] imem_wd_o,
    output logic        cpu_reset_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        error_o
);
    localparam int unsigned     TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TMO_W-1:0] TMO_SAT  = TMO_W'(TIMEOUT_CYCLES);

    loader_state_t    state_q, state_d;
    logic [7:0]       len_lo_q, len_lo_d;
    logic [15:0]      len_q, len_d;
    logic [29:0]      addr_q, addr_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             cpu_reset_q, cpu_reset_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             error_q, error_d;

    logic [15:0] len_new;
    logic        in_frame;
    logic        last_word;
    logic        pack_clr;
    logic        pack_valid;
    logic [1:0]  pack_idx;
    logic [31:0] pack_word;
    logic        pack_word_valid;

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [CHK_W-1:0] sum_q, sum_d;
`endif

    assign len_new   = {rx_data_i, len_lo_q};
    assign in_frame  = (state_q == LEN0) || (state_q == LEN1) ||
                       (state_q == DATA) || (state_q == CHK);
    assign last_word = (addr_q == (30'(len_q) - 30'd1));

    word_packer u_packer (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .clr_i        (pack_clr),
        .byte_valid_i (pack_valid),
        .byte_i       (rx_data_i),
        .idx_o        (pack_idx),
        .word_o       (pack_word),
        .word_valid_o (pack_word_valid)
    );

    always_comb begin
        state_d    = state_q;
        len_lo_d   = len_lo_q;
        len_d      = len_q;
        addr_d     = addr_q;
        tmo_d      = '0;
        done_d     = 1'b0;
        pack_clr   = 1'b0;
        pack_valid = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
        sum_d      = sum_q;
`endif
        // The address advances while the word it names is on the write port.
        if (pack_word_valid) begin
            addr_d = addr_q + 30'd1;
        end
        if (in_frame && !rx_valid_i) begin
            tmo_d = (tmo_q == TMO_SAT) ? tmo_q : tmo_q + TMO_W'(1);
        end

        case (state_q)
            IDLE, FAIL: begin
                if (rx_valid_i && (rx_data_i == SYNC_BYTE)) begin
                    state_d  = LEN0;
                    addr_d   = '0;
                    pack_clr = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    sum_d    = '0;
`endif
                end
            end
            LEN0: begin
                if (rx_valid_i) begin
                    len_lo_d = rx_data_i;
                    state_d  = LEN1;
                end
            end
            LEN1: begin
                if (rx_valid_i) begin
                    len_d = len_new;
                    if (32'(len_new) > MAX_WORDS) begin
                        state_d = FAIL;
                    end else if (len_new == 16'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        state_d = CHK;
`else
                        state_d = IDLE;
                        done_d  = 1'b1;
`endif
                    end else begin
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                if (rx_valid_i) begin
                    pack_valid = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    sum_d      = sum_q + rx_data_i;
`endif
                    if ((pack_idx == 2'd3) && last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        state_d = CHK;
`else
                        state_d = IDLE;
                        done_d  = 1'b1;
`endif
                    end
                end
            end
            CHK: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                if (rx_valid_i) begin
                    if (rx_data_i == sum_q) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = FAIL;
                    end
                end
`else
                state_d = IDLE;
`endif
            end
            default: state_d = IDLE;
        endcase

        if (in_frame && !rx_valid_i && (tmo_q == TMO_LAST)) begin
            state_d = FAIL;
            done_d  = 1'b0;
        end

        // Flags follow the state being entered so they are valid one cycle after the byte.
        cpu_reset_d = (state_d != IDLE);
        busy_d      = (state_d == LEN0) || (state_d == LEN1) ||
                      (state_d == DATA) || (state_d == CHK);
        error_d     = (state_d == FAIL);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            len_lo_q    <= '0;
            len_q       <= '0;
            addr_q      <= '0;
            tmo_q       <= '0;
            cpu_reset_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_lo_q    <= len_lo_d;
            len_q       <= len_d;
            addr_q      <= addr_d;
            tmo_q       <= tmo_d;
            cpu_reset_q <= cpu_reset_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
        end
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end
`endif

    assign imem_a_o    = addr_q;
    assign imem_we_o   = pack_word_valid;
    assign imem_wd_o   = pack_word;
    assign cpu_reset_o = cpu_reset_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign error_o     = error_q;

endmodule

// File: tb/tb_imem_loader.sv
// Randomized frame bench for imem_loader with a frame-level reference model.
module tb_imem_loader;
    localparam int TMO  = 40;
    localparam int MAXW = 8192;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [29:0] imem_a_o;
    logic        imem_we_o;
    logic [31:0] imem_wd_o;
    logic        cpu_reset_o;
    logic        busy_o;
    logic        done_o;
    logic        error_o;

    always #5 clk = ~clk;

    imem_loader #(
        .MAX_WORDS      (MAXW),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .rx_data_i   (rx_data),
        .rx_valid_i  (rx_valid),
        .imem_a_o    (imem_a_o),
        .imem_we_o   (imem_we_o),
        .imem_wd_o   (imem_wd_o),
        .cpu_reset_o (cpu_reset_o),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .error_o     (error_o)
    );

    typedef struct {
        int          cyc;
        logic [29:0] a;
        logic [31:0] d;
    } wr_t;

    wr_t        obs_wr[$];
    int         obs_done[$];
    logic       obs_done_cpu[$];
    logic [7:0] pl_q[$];
    int         ncyc      = 0;
    int         rise_cyc  = -1;
    logic       cpu_prev  = 1'b0;
    int         checks    = 0;
    int         errors    = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Outputs are all registered, so sampling on the falling edge is race-free.
    always @(negedge clk) begin
        ncyc = ncyc + 1;
        if (imem_we_o) obs_wr.push_back('{ncyc, imem_a_o, imem_wd_o});
        if (done_o) begin
            obs_done.push_back(ncyc);
            obs_done_cpu.push_back(cpu_reset_o);
        end
        if (cpu_reset_o && !cpu_prev && rise_cyc < 0) rise_cyc = ncyc;
        cpu_prev = cpu_reset_o;
    end

    // Called just after a falling edge; the byte is sampled on the next rising edge.
    task automatic send_byte(input logic [7:0] b, input int gap, output int tag);
        rx_data  = b;
        rx_valid = 1'b1;
        tag      = ncyc;
        @(negedge clk); #1;
        rx_valid = 1'b0;
        repeat (gap) begin
            @(negedge clk); #1;
        end
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin
            @(negedge clk); #1;
        end
    endtask

    task automatic send_garbage(input int n);
        logic [7:0] g;
        int         tg;
        for (int i = 0; i < n; i++) begin
            g = 8'($urandom);
            if (g == 8'hA5) g = 8'h5A;
            send_byte(g, 0, tg);
            check_eq("garbage_busy", busy_o, 0);
        end
    endtask

    function automatic logic [7:0] payload_sum();
        logic [7:0] s;
        s = 8'h00;
        foreach (pl_q[i]) s = s + pl_q[i];
        return s;
    endfunction

    // Sends one frame built from pl_q and compares against what the framing rules predict.
    task automatic run_frame(input string name, input int len, input logic [7:0] chk, input int max_gap);
        logic [7:0]  fb[$];
        int          tags[$];
        int          tg;
        int          nw;
        bit          ok;
        logic        start_cpu;
        logic [31:0] exp_w;

        fb.push_back(8'hA5);
        fb.push_back(len[7:0]);
        fb.push_back(len[15:8]);
        ok = (len <= MAXW);
        if (ok) begin
            foreach (pl_q[i]) fb.push_back(pl_q[i]);
`ifdef IMEM_LOADER_CHECKSUM_EN
            fb.push_back(chk);
            ok = (chk == payload_sum());
`endif
        end
        nw = (len <= MAXW) ? len : 0;

        obs_wr.delete();
        obs_done.delete();
        obs_done_cpu.delete();
        rise_cyc  = -1;
        start_cpu = cpu_reset_o;

        foreach (fb[i]) begin
            send_byte(fb[i], (i == fb.size() - 1) ? 0 : int'($urandom_range(0, max_gap)), tg);
            tags.push_back(tg);
        end
        idle_cycles(4);

        check_eq({name, "_nwr"}, obs_wr.size(), nw);
        for (int k = 0; k < nw && k < obs_wr.size(); k++) begin
            exp_w = {pl_q[4*k+3], pl_q[4*k+2], pl_q[4*k+1], pl_q[4*k]};
            check_eq({name, "_addr"}, obs_wr[k].a, k);
            check_eq({name, "_data"}, obs_wr[k].d, exp_w);
            check_eq({name, "_wcyc"}, obs_wr[k].cyc, tags[3+4*k+3] + 1);
        end
        check_eq({name, "_ndone"}, obs_done.size(), ok);
        if (obs_done.size() > 0 && ok) begin
            check_eq({name, "_dcyc"}, obs_done[0], tags[tags.size()-1] + 1);
            check_eq({name, "_dcpu"}, obs_done_cpu[0], 0);
        end
        if (!start_cpu) check_eq({name, "_rise"}, rise_cyc, tags[0] + 1);
        check_eq({name, "_err"}, error_o, !ok);
        check_eq({name, "_cpu"}, cpu_reset_o, !ok);
        check_eq({name, "_busy"}, busy_o, 0);
        $display("frame %s len=%0d words=%0d accepted=%0d", name, len, nw, ok);
    endtask

    initial begin
        int         tg;
        int         kind;
        int         len;
        logic [7:0] c;
        logic [7:0] s;

        rst      = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        idle_cycles(3);
        check_eq("rst_a_wd", {imem_a_o, imem_wd_o}, 0);
        check_eq("rst_flags", {imem_we_o, cpu_reset_o, busy_o, done_o, error_o}, 0);
        rst = 1'b0;
        idle_cycles(2);
        check_eq("post_rst_flags", {imem_we_o, cpu_reset_o, busy_o, done_o, error_o}, 0);

        // Two-word reference frame, bytes back to back.
        pl_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        run_frame("planA", 2, 8'h64, 0);
`ifdef IMEM_LOADER_CHECKSUM_EN
        run_frame("badchk", 2, 8'h65, 0);
        run_frame("recover", 2, 8'h64, 2);
`endif

        pl_q.delete();
        run_frame("overlen", 16'h2001, 8'h00, 0);
        run_frame("overlen_edge", MAXW + 1, 8'h00, 1);

        // Stall after the second payload byte.
        obs_wr.delete();
        send_byte(8'hA5, 0, tg);
        send_byte(8'h02, 0, tg);
        send_byte(8'h00, 0, tg);
        send_byte(8'h11, 0, tg);
        send_byte(8'h22, 0, tg);
        idle_cycles(10);
        check_eq("tmo_busy_early", busy_o, 1);
        check_eq("tmo_err_early", error_o, 0);
        idle_cycles(TMO);
        check_eq("tmo_err", error_o, 1);
        check_eq("tmo_cpu", cpu_reset_o, 1);
        check_eq("tmo_busy", busy_o, 0);
        check_eq("tmo_nwr", obs_wr.size(), 0);
        $display("frame timeout stalled after 2 payload bytes");

        // Reset in the middle of word 1.
        obs_wr.delete();
        send_byte(8'hA5, 0, tg);
        send_byte(8'h02, 0, tg);
        send_byte(8'h00, 0, tg);
        for (int i = 0; i < 6; i++) send_byte(8'(8'h30 + i), 1, tg);
        rst = 1'b1;
        #1;
        check_eq("midrst_a_wd", {imem_a_o, imem_wd_o}, 0);
        check_eq("midrst_flags", {imem_we_o, cpu_reset_o, busy_o, done_o, error_o}, 0);
        idle_cycles(2);
        rst = 1'b0;
        idle_cycles(3);
        check_eq("midrst_nwr", obs_wr.size(), 1);
        $display("frame midrst aborted after word 0");
        pl_q = '{8'h01, 8'h02, 8'h03, 8'h04};
        run_frame("after_rst", 1, payload_sum(), 1);

        send_byte(8'h00, 0, tg);
        check_eq("garb00_busy", busy_o, 0);
        send_byte(8'hFF, 0, tg);
        check_eq("garbFF_busy", busy_o, 0);
        send_byte(8'h5A, 0, tg);
        check_eq("garb5A_busy", busy_o, 0);
        $display("frame garbage 00 FF 5A");

        pl_q = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        run_frame("deadbeef", 1, 8'h38, 0);
        pl_q.delete();
        run_frame("zerolen", 0, 8'h00, 0);

        for (int f = 0; f < 25; f++) begin
            kind = $urandom_range(0, 9);
            if ($urandom_range(0, 3) == 0) send_garbage($urandom_range(1, 3));
            pl_q.delete();
            if (kind == 0)      len = MAXW + 1 + $urandom_range(0, 2000);
            else if (kind == 1) len = 0;
            else                len = $urandom_range(1, 6);
            if (len <= MAXW) begin
                for (int i = 0; i < len * 4; i++) pl_q.push_back(8'($urandom));
            end
            s = payload_sum();
            c = s;
            if (kind == 2) c = s + 8'($urandom_range(1, 255));
            run_frame($sformatf("rnd%0d", f), len, c, 3);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
# imem_loader

Serial bootloader stage directly upstream of the instruction memory's data-side write port. Consumes a byte stream from the UART receiver, frames and validates it, and writes assembled 32-bit little-endian words into instruction memory. Holds the CPU in reset while loading, then releases it.

## Interface
- MAX_WORDS, 8192: instruction memory depth in words; larger lengths are rejected.
- TIMEOUT_CYCLES, 5_000_000: maximum idle cycles between bytes inside a frame.
- CLK  in  1  system clock; all logic on the rising edge.
- RESET  in  1  asynchronous, active-high reset.
- RX_DATA  in  8  received byte from the UART receiver.
- RX_VALID  in  1  one-cycle strobe; RX_DATA is valid. No backpressure; every strobe is consumed.
- IMEM_A  out  30  word address to the instruction memory data port.
- IMEM_WE  out  1  one-cycle write strobe.
- IMEM_WD  out  32  write data.
- CPU_RESET  out  1  held high while a load is in progress or has failed.
- BUSY  out  1  high in any frame-receiving state.
- DONE  out  1  one-cycle pulse on a successful load.
- ERROR  out  1  sticky fault flag; cleared by RESET or the next sync byte.

## Operation
- Frame: sync byte 0xA5, LEN_LO, LEN_HI (LEN in words), LEN×4 payload bytes (LSB first per word), then CHK (if checksum compiled in).
- States: IDLE, LEN0, LEN1, DATA, CHK, FAIL.
- IDLE: bytes other than 0xA5 are ignored. 0xA5 → LEN0, CPU_RESET=1, ERROR=0, word address cleared, checksum accumulator cleared.
- LEN0 → LEN1 on a byte (captures LEN_LO). LEN1 on a byte: if LEN > MAX_WORDS → FAIL; if LEN == 0 → CHK (or IDLE with DONE when checksum is compiled out); otherwise → DATA.
- DATA: a 2-bit byte index fills the word from bits [7:0] upward. On the 4th byte, the word is written at the current address and the address increments. After word LEN-1 → CHK (or IDLE with DONE).
- CHK: the 8-bit sum mod 256 of all payload bytes (not sync or length) is compared with the received byte. On a match → IDLE with DONE=1 and CPU_RESET=0. On a mismatch → FAIL.
- FAIL: ERROR=1 and CPU_RESET=1. Only 0xA5 restarts, which behaves exactly as in IDLE.
- Timeout: a counter is cleared on every RX_VALID and increments otherwise in LEN0, LEN1, DATA and CHK. Reaching TIMEOUT_CYCLES → FAIL.
- A partially loaded memory is never released to the CPU.

## Timing
- Reset values: IMEM_A=0, IMEM_WE=0, IMEM_WD=0, CPU_RESET=0 (CPU runs the preloaded image), BUSY=0, DONE=0, ERROR=0, state IDLE.
- All outputs are registered.
- IMEM_WE is high for exactly the one cycle after the edge on which the 4th byte's RX_VALID is sampled. IMEM_A and IMEM_WD are stable in that cycle.
- CPU_RESET rises the cycle after the sync byte is sampled. It falls in the same cycle DONE pulses, which is one cycle after the last accepted byte.
- Back-to-back RX_VALID on consecutive cycles must be supported without byte loss.
- RESET asserted mid-frame aborts immediately. No further writes occur, and CPU_RESET drops to 0.
- Address arithmetic is 30-bit and cannot wrap, because LEN ≤ MAX_WORDS.
- The timeout counter is $clog2(TIMEOUT_CYCLES+1) bits wide and saturates.

## Configuration
- IMEM_LOADER_CHECKSUM_EN: when defined, the CHK state and the accumulator exist and the frame ends with CHK. When undefined, there is no CHK byte, DONE follows the last payload byte (or LEN1 when LEN==0), and mismatch failure is impossible.

## Structure
- Package loader_pkg holds the state enum loader_state_t, the constant SYNC_BYTE = 8'hA5, and the checksum width.
- One sub-module, word_packer, does the byte-to-word assembly. It takes the byte strobe and a clear input, and outputs a word plus a word-valid pulse.

## Test plan
- Frame A5 02 00 11 22 33 44 55 66 77 88 CHK=0x64 → writes 0x44332211@0 and 0x88776655@1, DONE pulse, CPU_RESET 1→0.
- Same frame with CHK=0x65 → both writes occur, then ERROR=1, CPU_RESET stays 1, no DONE. A following valid frame clears ERROR.
- A5 01 20 (LEN=0x2001 > 8192) → FAIL immediately after LEN_HI, no IMEM_WE.
- Timeout: stall TIMEOUT_CYCLES after the 2nd payload byte → ERROR=1, no write for the partial word.
- RESET asserted between bytes of word 1 → all outputs return to reset values; the next frame loads from address 0.
- Garbage bytes 00 FF 5A in IDLE → ignored, BUSY stays 0. With the macro undefined, A5 01 00 DE AD BE EF → 0xEFBEADDE@0 and DONE.
